// File: rtl/reaction_trial_sequencer.sv
// Multi-trial reaction test sequencer: random pre-delay, LED stimulus, reaction timing, best/average.
// Define EARLY_RETRY_EN to repeat a trial after an early press instead of recording a penalty.
module reaction_trial_sequencer #(
  parameter int unsigned LOG2_TRIALS  = 2,
  parameter int unsigned LIMIT_MS     = 1000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter logic [13:0] DELAY_MASK   = 14'h0FFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick_1ms,
  input  logic                   start,
  input  logic                   stop,
  input  logic [13:0]            rnd,
  output logic                   led,
  output logic                   busy,
  output logic [LOG2_TRIALS-1:0] trial_idx,
  output logic [13:0]            last_time,
  output logic                   last_valid,
  output logic                   early,
  output logic                   late,
  output logic [13:0]            best_time,
  output logic [13:0]            avg_time,
  output logic                   done
);

  localparam int unsigned          SUM_W      = 14 + LOG2_TRIALS;
  localparam logic [13:0]          LIMIT      = 14'(LIMIT_MS);
  localparam logic [13:0]          MIN_DELAY  = 14'(MIN_DELAY_MS);
  localparam logic [13:0]          TIME_MAX   = 14'h3FFF;
  localparam logic [LOG2_TRIALS-1:0] LAST_TRIAL = '1;

  // S_AVG is the single clock after the final record where the average is registered.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_TEST = 3'd3;
  localparam logic [2:0] S_AVG  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state;
  logic [13:0]      cnt;
  logic [SUM_W-1:0] sum;
  logic             start_q;
  logic             stop_q;
  logic             start_rise;
  logic             stop_rise;
  logic [14:0]      delay_raw;
  logic [13:0]      delay_sat;
  logic             rec_en;
  logic [13:0]      rec_value;
  logic             rec_early;
  logic             rec_late;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign delay_raw  = {1'b0, MIN_DELAY} + {1'b0, rnd & DELAY_MASK};
  assign delay_sat  = delay_raw[14] ? TIME_MAX : delay_raw[13:0];

  // Decide whether this clock closes a trial and with what value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    rec_en    = 1'b0;
    rec_value = cnt;
    rec_early = 1'b0;
    rec_late  = 1'b0;
    if (state == S_WAIT && stop_rise) begin
`ifndef EARLY_RETRY_EN
      rec_en    = 1'b1;
      rec_value = LIMIT;
      rec_early = 1'b1;
`endif
    end else if (state == S_TEST) begin
      if (stop_rise) begin
        rec_en = 1'b1;
      end else if (tick_1ms && cnt == LIMIT - 14'd1) begin
        rec_en    = 1'b1;
        rec_value = LIMIT;
        rec_late  = 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sum        <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      led        <= 1'b0;
      busy       <= 1'b0;
      trial_idx  <= '0;
      last_time  <= '0;
      last_valid <= 1'b0;
      early      <= 1'b0;
      late       <= 1'b0;
      best_time  <= TIME_MAX;
      avg_time   <= '0;
      done       <= 1'b0;
    end else begin
      start_q    <= start;
      stop_q     <= stop;
      last_valid <= 1'b0;
      if (rec_en) begin
        last_time  <= rec_value;
        last_valid <= 1'b1;
        sum        <= sum + SUM_W'(rec_value);
        if (rec_value < best_time) best_time <= rec_value;
        early      <= rec_early;
        late       <= rec_late;
        led        <= 1'b0;
        if (trial_idx == LAST_TRIAL) begin
          state <= S_AVG;
        end else begin
          trial_idx <= trial_idx + LOG2_TRIALS'(1);
          state     <= S_ARM;
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_rise) begin
              sum       <= '0;
              trial_idx <= '0;
              best_time <= TIME_MAX;
              done      <= 1'b0;
              early     <= 1'b0;
              late      <= 1'b0;
              busy      <= 1'b1;
              state     <= S_ARM;
            end
          end
          S_ARM: begin
            cnt   <= delay_sat;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (stop_rise) begin
`ifdef EARLY_RETRY_EN
              // Retry: flag the early press, keep the trial slot, draw a new delay.
              early      <= 1'b1;
              late       <= 1'b0;
              last_valid <= 1'b1;
              led        <= 1'b0;
              state      <= S_ARM;
`endif
            end else if (tick_1ms) begin
              if (cnt <= 14'd1) begin
                cnt   <= '0;
                led   <= 1'b1;
                state <= S_TEST;
              end else begin
                cnt <= cnt - 14'd1;
              end
            end
          end
          S_TEST: begin
            if (tick_1ms) cnt <= cnt + 14'd1;
          end
          S_AVG: begin
            avg_time <= 14'(sum >> LOG2_TRIALS);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_trial_sequencer.sv
// Self-checking bench for reaction_trial_sequencer: directed sessions plus randomized traffic
// checked every cycle against a queue-based behavioural model of a session.
module tb_reaction_trial_sequencer;

  localparam int NT        = 4;
  localparam int LIMIT     = 1000;
  localparam int MIN_DELAY = 1000;
  localparam int MASK      = 'h0FFF;
  localparam int TMAX      = 16383;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_1ms = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] rnd = '0;
  logic        led, busy, last_valid, early, late, done;
  logic [1:0]  trial_idx;
  logic [13:0] last_time, best_time, avg_time;

  reaction_trial_sequencer #(
    .LOG2_TRIALS(2), .LIMIT_MS(LIMIT), .MIN_DELAY_MS(MIN_DELAY), .DELAY_MASK(14'h0FFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_1ms(tick_1ms), .start(start), .stop(stop), .rnd(rnd),
    .led(led), .busy(busy), .trial_idx(trial_idx), .last_time(last_time),
    .last_valid(last_valid), .early(early), .late(late), .best_time(best_time),
    .avg_time(avg_time), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_ARM, P_WAIT, P_TEST, P_AVG, P_DONE} phase_t;
  phase_t phase = P_IDLE;
  int     remaining = 0;
  int     elapsed = 0;
  int     times[$];
  int     m_last_time = 0;
  bit     m_last_valid = 0;
  bit     m_early = 0;
  bit     m_late = 0;
  int     m_avg = 0;
  bit     prev_start = 0;
  bit     prev_stop = 0;

  function automatic int exp_best();
    int b = TMAX;
    foreach (times[i]) if (times[i] < b) b = times[i];
    return b;
  endfunction

  function automatic int exp_trial();
    return (times.size() >= NT) ? NT - 1 : times.size();
  endfunction

  task automatic model_record(input int v, input bit e, input bit l);
    m_last_time  = v;
    m_last_valid = 1'b1;
    times.push_back(v);
    m_early = e;
    m_late  = l;
    phase   = (times.size() == NT) ? P_AVG : P_ARM;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      phase = P_IDLE; remaining = 0; elapsed = 0; times.delete();
      m_last_time = 0; m_last_valid = 0; m_early = 0; m_late = 0; m_avg = 0;
      prev_start = 0; prev_stop = 0;
    end else begin
      bit srise, prise;
      int s;
      srise = start && !prev_start;
      prise = stop && !prev_stop;
      prev_start = start;
      prev_stop  = stop;
      m_last_valid = 1'b0;
      case (phase)
        P_IDLE, P_DONE: if (srise) begin
          times.delete(); m_early = 0; m_late = 0; phase = P_ARM;
        end
        P_ARM: begin
          remaining = MIN_DELAY + (int'(rnd) & MASK);
          if (remaining > TMAX) remaining = TMAX;
          phase = P_WAIT;
        end
        P_WAIT: begin
          if (prise) begin
`ifdef EARLY_RETRY_EN
            m_early = 1; m_late = 0; m_last_valid = 1; phase = P_ARM;
`else
            model_record(LIMIT, 1'b1, 1'b0);
`endif
          end else if (tick_1ms) begin
            if (remaining <= 1) begin phase = P_TEST; elapsed = 0; end
            else remaining--;
          end
        end
        P_TEST: begin
          if (prise) model_record(elapsed, 1'b0, 1'b0);
          else if (tick_1ms) begin
            elapsed++;
            if (elapsed == LIMIT) model_record(LIMIT, 1'b0, 1'b1);
          end
        end
        P_AVG: begin
          s = 0;
          foreach (times[i]) s += times[i];
          m_avg = s / NT;
          phase = P_DONE;
        end
        default: phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("led", led, int'(phase == P_TEST));
    check("busy", busy, int'(phase != P_IDLE && phase != P_DONE));
    check("done", done, int'(phase == P_DONE));
    check("trial_idx", trial_idx, exp_trial());
    check("last_time", last_time, m_last_time);
    check("last_valid", last_valid, m_last_valid);
    check("early", early, m_early);
    check("late", late, m_late);
    check("best_time", best_time, exp_best());
    check("avg_time", avg_time, m_avg);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit t, input bit sp);
    tick_1ms = t;
    stop     = sp;
    @(posedge clk);
    #1;
  endtask

  // One trial with rnd=0: 1000-tick pre-delay, then a stop after 'react' ticks.
  task automatic trial_stop(input int react);
    cyc(0, 0);
    repeat (999) cyc(1, 0);
    check("lit_led_before_1000th", led, 0);
    cyc(1, 0);
    check("lit_led_on_1000th", led, 1);
    repeat (react) cyc(1, 0);
    cyc(0, 1);
    check("lit_stop_valid", last_valid, 1);
    check("lit_stop_time", last_time, react);
    check("lit_stop_led_off", led, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0);
    check("lit_reset_best", best_time, 'h3FFF);
    check("lit_reset_busy", busy, 0);
    check("lit_reset_idx", trial_idx, 0);
    reset_n = 1'b1;
    repeat (2) cyc(0, 0);

    // Session A: start held for the whole session; stops at 200..500 ms.
    start = 1'b1;
    cyc(0, 0);
    check("lit_busy_after_start", busy, 1);
    trial_stop(200);
    check("lit_idx_after_first", trial_idx, 1);
    cyc(0, 0);
    check("lit_valid_one_clk", last_valid, 0);
    // cyc above was the ARM clock of trial 2; finish trial 2 without the leading ARM cycle
    repeat (999) cyc(1, 0);
    cyc(1, 0);
    repeat (300) cyc(1, 0);
    cyc(0, 1);
    check("lit_t2_time", last_time, 300);
    trial_stop(400);
    trial_stop(500);
    check("lit_done_not_yet", done, 0);
    cyc(0, 0);
    check("lit_a_done", done, 1);
    check("lit_a_best", best_time, 200);
    check("lit_a_avg", avg_time, 350);
    check("lit_a_busy", busy, 0);
    check("lit_a_idx", trial_idx, 3);
    repeat (5) cyc(0, 0);
    check("lit_held_start_no_restart", busy, 0);
    start = 1'b0;
    cyc(0, 0);
    start = 1'b1;
    cyc(0, 0);
    check("lit_repress_busy", busy, 1);
    check("lit_repress_best", best_time, 'h3FFF);
    check("lit_repress_done", done, 0);

    // Session B: early, 250, late, stop-with-limit-tick (and a retry trial if enabled).
    cyc(0, 0);
    repeat (500) cyc(1, 0);
    cyc(0, 1);
    check("lit_early_flag", early, 1);
    check("lit_early_valid", last_valid, 1);
`ifdef EARLY_RETRY_EN
    check("lit_early_idx", trial_idx, 0);
    check("lit_early_time_kept", last_time, 500);
    check("lit_early_best", best_time, 'h3FFF);
`else
    check("lit_early_idx", trial_idx, 1);
    check("lit_early_time", last_time, 1000);
`endif
    trial_stop(250);
    check("lit_250_early_clr", early, 0);
    cyc(0, 0);
    repeat (1000) cyc(1, 0);
    repeat (999) cyc(1, 0);
    check("lit_late_not_yet", late, 0);
    cyc(1, 0);
    check("lit_late_flag", late, 1);
    check("lit_late_time", last_time, 1000);
    check("lit_late_led", led, 0);
    cyc(0, 0);
    repeat (1000) cyc(1, 0);
    repeat (999) cyc(1, 0);
    cyc(1, 1);
    check("lit_coincide_time", last_time, 999);
    check("lit_coincide_late", late, 0);
`ifdef EARLY_RETRY_EN
    trial_stop(300);
    cyc(0, 0);
    check("lit_b_avg", avg_time, 637);
`else
    cyc(0, 0);
    check("lit_b_avg", avg_time, 812);
`endif
    check("lit_b_best", best_time, 250);
    check("lit_b_done", done, 1);

    // Session C: reset in the middle of TEST.
    start = 1'b0;
    cyc(0, 0);
    start = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    repeat (1000) cyc(1, 0);
    repeat (10) cyc(1, 0);
    check("lit_c_led_on", led, 1);
    reset_n = 1'b0;
    #1;
    check("lit_rst_led", led, 0);
    check("lit_rst_best", best_time, 'h3FFF);
    check("lit_rst_idx", trial_idx, 0);
    check("lit_rst_busy", busy, 0);
    start = 1'b0;
    repeat (2) cyc(0, 0);
    reset_n = 1'b1;
    cyc(0, 0);

    // Randomized traffic; stop probability depends on the model's phase to mix early/normal/late.
    for (int i = 0; i < 30000; i++) begin
      bit sp;
      rnd   = 14'((($urandom_range(0, 3)) << 12) | $urandom_range(0, 300));
      start = ($urandom_range(0, 39) == 0);
      if (phase == P_TEST)      sp = ($urandom_range(0, 899) == 0);
      else if (phase == P_WAIT) sp = ($urandom_range(0, 3999) == 0);
      else                      sp = ($urandom_range(0, 49) == 0);
      cyc($urandom_range(0, 3) != 0, sp);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
